// File: rtl/deser_pkg.sv
// Shared types and constants for deserializer_par and its accumulator.
package deser_pkg;

  localparam int unsigned OVF_CNT_W = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

  typedef enum logic {StEmpty, StFull} out_state_e;

  // Width needed to hold a bit count of 0..data_w.
  function automatic int unsigned MOD_W(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/deser_accum.sv
// Serial bit accumulator: places bits in LSB- or MSB-first order and strobes `done`
// with the zero-filled word and its valid-bit count on a full word or a non-empty flush.
module deser_accum import deser_pkg::*; #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      data,
  input  logic                      data_val,
  input  logic                      flush,
  output logic [DATA_W-1:0]         word,
  output logic [MOD_W(DATA_W)-1:0]  mod,
  output logic                      done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned MW    = MOD_W(DATA_W);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_ins;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  pos;
  logic [MW-1:0]     bits;
  logic              full;

  always_comb begin
    pos     = (MSB_FIRST != 0) ? (CNT_W'(DATA_W - 1) - cnt_q) : cnt_q;
    acc_ins = acc_q;
    if (data_val) begin
      acc_ins[pos] = data;
    end
    // Count includes a bit accepted this cycle, so a flush on that bit keeps it.
    bits = MW'(cnt_q) + MW'(data_val);
    full = data_val && (cnt_q == CNT_W'(DATA_W - 1));
    done = full || (flush && (bits != '0));
  end

  assign word = acc_ins;
  assign mod  = bits;

  always_ff @(posedge clk) begin
    if (srst || done) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (data_val) begin
      acc_q <= acc_ins;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer_par.sv
// Parametrised serial-to-parallel converter with flush, valid/ready output and drop reporting.
// Optional saturating drop counter port enabled by defining DESER_OVF_CNT_EN.
module deserializer_par import deser_pkg::*; #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      data_i,
  input  logic                      data_val_i,
  input  logic                      flush_i,
  output logic [DATA_W-1:0]         deser_data_o,
  output logic [MOD_W(DATA_W)-1:0]  deser_data_mod_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_data_rdy_i,
  output logic                      deser_ovf_o
`ifdef DESER_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]      deser_ovf_cnt_o
`endif
);

  localparam int unsigned MW = MOD_W(DATA_W);

  logic [DATA_W-1:0] word;
  logic [MW-1:0]     mod;
  logic              done;
  logic              drop;

  out_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  logic [MW-1:0]     mod_q;
  logic              ovf_q;

  deser_accum #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_accum (
    .clk      (clk_i),
    .srst     (srst_i),
    .data     (data_i),
    .data_val (data_val_i),
    .flush    (flush_i),
    .word     (word),
    .mod      (mod),
    .done     (done)
  );

  // A completed word is lost only when the held word is not being taken this cycle.
  assign drop = (state_q == StFull) && !deser_data_rdy_i && done;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= StEmpty;
      data_q  <= '0;
      mod_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= drop;
      case (state_q)
        StEmpty: begin
          if (done) begin
            data_q  <= word;
            mod_q   <= mod;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (deser_data_rdy_i) begin
            if (done) begin
              data_q <= word;
              mod_q  <= mod;
            end else begin
              state_q <= StEmpty;
            end
          end
        end
      endcase
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = (state_q == StFull);
  assign deser_ovf_o      = ovf_q;

`ifdef DESER_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != OVF_CNT_MAX)) begin
      ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
    end
  end

  assign deser_ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_deserializer_par.sv
// Bench for deserializer_par: a 16-bit LSB-first and an 8-bit MSB-first instance,
// checked through a word scoreboard plus direct checks on latency, overflow and reset.
module tb_deserializer_par;

  logic clk = 1'b0;
  logic srst = 1'b1;

  logic d16 = 1'b0, v16 = 1'b0, f16 = 1'b0, r16 = 1'b1;
  logic [15:0] o16_data;
  logic [4:0]  o16_mod;
  logic        o16_val, o16_ovf;

  logic d8 = 1'b0, v8 = 1'b0, f8 = 1'b0, r8 = 1'b1;
  logic [7:0] o8_data;
  logic [3:0] o8_mod;
  logic       o8_val, o8_ovf;

`ifdef DESER_OVF_CNT_EN
  logic [7:0] cnt16, cnt8;
`endif

  always #5 clk = ~clk;

  deserializer_par #(.DATA_W(16), .MSB_FIRST(0)) dut16 (
    .clk_i            (clk),
    .srst_i           (srst),
    .data_i           (d16),
    .data_val_i       (v16),
    .flush_i          (f16),
    .deser_data_o     (o16_data),
    .deser_data_mod_o (o16_mod),
    .deser_data_val_o (o16_val),
    .deser_data_rdy_i (r16),
    .deser_ovf_o      (o16_ovf)
`ifdef DESER_OVF_CNT_EN
    ,
    .deser_ovf_cnt_o  (cnt16)
`endif
  );

  deserializer_par #(.DATA_W(8), .MSB_FIRST(1)) dut8 (
    .clk_i            (clk),
    .srst_i           (srst),
    .data_i           (d8),
    .data_val_i       (v8),
    .flush_i          (f8),
    .deser_data_o     (o8_data),
    .deser_data_mod_o (o8_mod),
    .deser_data_val_o (o8_val),
    .deser_data_rdy_i (r8),
    .deser_ovf_o      (o8_ovf)
`ifdef DESER_OVF_CNT_EN
    ,
    .deser_ovf_cnt_o  (cnt8)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  mod;
  } word_t;

  typedef struct {
    logic [63:0] bits;
    int          n;
    bit          fl;
    logic [15:0] data;
    logic [4:0]  mod;
  } vec_t;

  word_t q16[$];
  word_t q8[$];
  word_t w16, w8;
  int ovf16 = 0;
  int ovf8  = 0;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a word is consumed at the edge after a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (!srst) begin
      if (o16_val && r16) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word16_unexpected: got 0x%0h mod %0d, expected no word", o16_data, o16_mod);
        end else begin
          w16 = q16.pop_front();
          check("word16_data", 32'(o16_data), 32'(w16.data));
          check("word16_mod", 32'(o16_mod), 32'(w16.mod));
        end
      end
      if (o8_val && r8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word8_unexpected: got 0x%0h mod %0d, expected no word", o8_data, o8_mod);
        end else begin
          w8 = q8.pop_front();
          check("word8_data", 32'(o8_data), 32'(w8.data));
          check("word8_mod", 32'(o8_mod), 32'(w8.mod));
        end
      end
      if (o16_ovf) ovf16++;
      if (o8_ovf) ovf8++;
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge that sampled them.
  task automatic step(input bit sel, input logic d, input logic v, input logic f);
    if (sel) begin
      d8 = d; v8 = v; f8 = f;
    end else begin
      d16 = d; v16 = v; f16 = f;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [63:0] bits, input int n, input bit fl);
    for (int i = 0; i < n; i++) begin
      step(sel, bits[i], 1'b1, fl && (i == n - 1));
    end
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      step(sel, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data16"}, 32'(o16_data), 32'h0);
    check({tag, "_mod16"}, 32'(o16_mod), 32'h0);
    check({tag, "_val16"}, 32'(o16_val), 32'h0);
    check({tag, "_ovf16"}, 32'(o16_ovf), 32'h0);
    check({tag, "_data8"}, 32'(o8_data), 32'h0);
    check({tag, "_mod8"}, 32'(o8_mod), 32'h0);
    check({tag, "_val8"}, 32'(o8_val), 32'h0);
`ifdef DESER_OVF_CNT_EN
    check({tag, "_cnt16"}, 32'(cnt16), 32'h0);
    check({tag, "_cnt8"}, 32'(cnt8), 32'h0);
`endif
  endtask

  initial begin
    int ovf_start;
    tbl[0] = '{64'h000D, 16, 1'b0, 16'h000D, 5'd16};
    tbl[1] = '{64'hFFFF, 16, 1'b0, 16'hFFFF, 5'd16};
    tbl[2] = '{64'hA5C3, 16, 1'b0, 16'hA5C3, 5'd16};
    tbl[3] = '{64'h0005, 3,  1'b1, 16'h0005, 5'd3};
    tbl[4] = '{64'h8001, 16, 1'b1, 16'h8001, 5'd16};
    tbl[5] = '{64'h0001, 1,  1'b1, 16'h0001, 5'd1};
    tbl[6] = '{64'h7FFF, 15, 1'b1, 16'h7FFF, 5'd15};
    tbl[7] = '{64'h1234, 16, 1'b1, 16'h1234, 5'd16};

    @(posedge clk);
    #1;
    idle(1'b0, 2);
    check_zero("reset");
    srst = 1'b0;
    idle(1'b0, 1);

    // Full word, latency: valid in the cycle right after the 16th bit.
    q16.push_back('{16'h000D, 5'd16});
    send(1'b0, 64'h000D, 16, 1'b0);
    check("full_latency_val", 32'(o16_val), 32'h1);
    check("full_latency_data", 32'(o16_data), 32'h000D);
    idle(1'b0, 1);
    check("full_consumed_val", 32'(o16_val), 32'h0);

    // Table vectors applied with no gaps between words.
    for (int i = 0; i < 8; i++) begin
      q16.push_back('{tbl[i].data, tbl[i].mod});
      send(1'b0, tbl[i].bits, tbl[i].n, tbl[i].fl);
    end
    idle(1'b0, 3);

    // 32 consecutive bits: second word is presented right after its last bit.
    q16.push_back('{16'hBEEF, 5'd16});
    q16.push_back('{16'h1357, 5'd16});
    send(1'b0, 64'hBEEF, 16, 1'b0);
    send(1'b0, 64'h1357, 16, 1'b0);
    check("b2b_val", 32'(o16_val), 32'h1);
    check("b2b_data", 32'(o16_data), 32'h1357);
    idle(1'b0, 2);
    check("b2b_no_ovf", 32'(ovf16), 32'h0);

    // Flush on an idle cycle, then a flush with nothing accumulated.
    q16.push_back('{16'h0003, 5'd3});
    send(1'b0, 64'h0003, 3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_flush_mod", 32'(o16_mod), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    check("empty_flush_no_word", 32'(o16_val), 32'h0);

    // MSB-first partial flush then an immediately following full word.
    q8.push_back('{16'h00A0, 5'd3});
    send(1'b1, 64'h5, 3, 1'b1);
    check("msb_partial_val", 32'(o8_val), 32'h1);
    check("msb_partial_data", 32'(o8_data), 32'hA0);
    check("msb_partial_mod", 32'(o8_mod), 32'h3);
    q8.push_back('{16'h00CA, 5'd8});
    send(1'b1, 64'h53, 8, 1'b0);
    check("msb_full_data", 32'(o8_data), 32'hCA);
    idle(1'b1, 2);

    // Backpressure: second completion is dropped, held word unchanged.
    r16 = 1'b0;
    ovf_start = ovf16;
    q16.push_back('{16'h1111, 5'd16});
    send(1'b0, 64'h1111, 16, 1'b0);
    send(1'b0, 64'h2222, 16, 1'b0);
    check("ovf_pulse", 32'(o16_ovf), 32'h1);
    check("ovf_hold_data", 32'(o16_data), 32'h1111);
    check("ovf_hold_mod", 32'(o16_mod), 32'd16);
    idle(1'b0, 1);
    check("ovf_pulse_end", 32'(o16_ovf), 32'h0);
    check("ovf_pulse_count", 32'(ovf16 - ovf_start), 32'd1);
`ifdef DESER_OVF_CNT_EN
    check("ovf_cnt_one", 32'(cnt16), 32'd1);
`endif
    r16 = 1'b1;
    idle(1'b0, 2);

    // Many drops: counter saturates, pulses keep coming one per drop.
    r16 = 1'b0;
    q16.push_back('{16'h00F0, 5'd16});
    send(1'b0, 64'h00F0, 16, 1'b0);
    ovf_start = ovf16;
    for (int k = 0; k < 300; k++) begin
      send(1'b0, 64'hFFFF, 16, 1'b0);
    end
    idle(1'b0, 2);
    check("ovf_300_pulses", 32'(ovf16 - ovf_start), 32'd300);
    check("ovf_300_hold", 32'(o16_data), 32'h00F0);
`ifdef DESER_OVF_CNT_EN
    check("ovf_cnt_sat", 32'(cnt16), 32'd255);
`endif
    r16 = 1'b1;
    idle(1'b0, 2);

    // Reset mid-word discards the partial bits.
    send(1'b0, 64'h1F, 5, 1'b0);
    srst = 1'b1;
    idle(1'b0, 1);
    check_zero("midreset");
    srst = 1'b0;
    q16.push_back('{16'h0042, 5'd16});
    send(1'b0, 64'h0042, 16, 1'b0);
    check("post_reset_val", 32'(o16_val), 32'h1);
    idle(1'b0, 3);

    check("q16_drained", 32'(q16.size()), 32'h0);
    check("q8_drained", 32'(q8.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
